// File: rtl/lsu_dmem_port_if.sv
// Core-request / response / data-memory bundle for lsu_dmem_port.
// slave: the load/store unit side; master: the core-plus-memory side.
`ifndef XLEN
`define XLEN 32
`endif

interface lsu_dmem_port_if;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [`XLEN-1:0]  req_addr;
    logic [`XLEN-1:0]  req_wdata;

    logic              resp_valid;
    logic [`XLEN-1:0]  resp_rdata;
    logic              resp_err;

    logic              mem_we;
    logic [`XLEN-1:0]  mem_a;
    logic [`XLEN-1:0]  mem_wd;
    logic              mem_lb;
    logic              mem_lh;
    logic              mem_sb;
    logic              mem_sh;
    logic              mem_lu;
    logic [`XLEN-1:0]  mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_a, mem_wd, mem_lb, mem_lh, mem_sb, mem_sh, mem_lu
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_a, mem_wd, mem_lb, mem_lh, mem_sb, mem_sh, mem_lu
    );
endinterface

// File: rtl/lsu_dmem_port.sv
// Load/store unit data-memory port: accepts one RISC-V load/store at a time,
// performs it on a single-cycle data memory and returns a one-cycle response.
// Optional macro LSU_MISALIGN_SPLIT_EN: misaligned half/word accesses are
// broken into byte accesses; when undefined they are rejected with resp_err.
`ifndef XLEN
`define XLEN 32
`endif

module lsu_dmem_port (
    input  logic           clk,
    input  logic           reset,
    lsu_dmem_port_if.slave bus
);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
`ifdef LSU_MISALIGN_SPLIT_EN
        , SPLIT
`endif
    } state_t;

    state_t      state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic        req_ok;
    logic        req_mis;
    logic        req_reject;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]       k;
    logic [`XLEN-1:0] wsh;
    logic [`XLEN-1:0] asm;
    logic [`XLEN-1:0] asm_next;
`endif

    // {1,1}=word, {1,0}=half, {0,1}=byte
    function automatic logic [1:0] size_code(input logic [1:0] sz);
        case (sz)
            2'b00:   size_code = 2'b01;
            2'b01:   size_code = 2'b10;
            default: size_code = 2'b11;
        endcase
    endfunction

    function automatic logic [`XLEN-1:0] extend(input logic [2:0] f3, input logic [`XLEN-1:0] d);
        case (f3)
            3'b000:  extend = {{(`XLEN-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(`XLEN-16){d[15]}}, d[15:0]};
            3'b100:  extend = {{(`XLEN-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(`XLEN-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // Request classification: legal funct3, alignment, and whether to reject
    always_comb begin
        if (bus.req_we)
            req_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                     (bus.req_funct3 == 3'b010);
        else
            req_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                     (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                     (bus.req_funct3 == 3'b101);
        req_mis = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_reject = !req_ok || (req_mis && !SPLIT_EN);
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Merge the byte returned this SPLIT cycle into lane k of the assembly word
    always_comb begin
        asm_next = asm;
        asm_next[{k, 3'b000} +: 8] = bus.mem_rd[7:0];
    end
`endif

    // Control FSM; every output is a register loaded on the edge entering its state
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            r_we           <= 1'b0;
            r_f3           <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            {bus.mem_we, bus.mem_lb, bus.mem_lh, bus.mem_sb, bus.mem_sh, bus.mem_lu} <= '0;
            bus.mem_a      <= '0;
            bus.mem_wd     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            k              <= '0;
            wsh            <= '0;
            asm            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we          <= bus.req_we;
                        r_f3          <= bus.req_funct3;
                        bus.req_ready <= 1'b0;
                        if (req_reject) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end
`ifdef LSU_MISALIGN_SPLIT_EN
                        // mem_a and wsh double as the address/data registers for the byte walk
                        else if (req_mis) begin
                            state      <= SPLIT;
                            k          <= '0;
                            asm        <= '0;
                            wsh        <= bus.req_wdata >> 8;
                            bus.mem_a  <= bus.req_addr;
                            bus.mem_we <= bus.req_we;
                            bus.mem_wd <= bus.req_we ? `XLEN'(bus.req_wdata[7:0]) : '0;
                            bus.mem_lb <= 1'b0;
                            bus.mem_lh <= !bus.req_we;
                            bus.mem_sb <= 1'b0;
                            bus.mem_sh <= bus.req_we;
                            bus.mem_lu <= 1'b1;
                        end
`endif
                        else begin
                            state      <= ACCESS;
                            bus.mem_a  <= bus.req_addr;
                            bus.mem_we <= bus.req_we;
                            bus.mem_wd <= bus.req_we ? bus.req_wdata : '0;
                            {bus.mem_lb, bus.mem_lh} <= bus.req_we ? 2'b00 : size_code(bus.req_funct3[1:0]);
                            {bus.mem_sb, bus.mem_sh} <= bus.req_we ? size_code(bus.req_funct3[1:0]) : 2'b00;
                            bus.mem_lu <= bus.req_funct3[2];
                        end
                    end
                end
                ACCESS: begin
                    state          <= RESP;
                    {bus.mem_we, bus.mem_lb, bus.mem_lh, bus.mem_sb, bus.mem_sh, bus.mem_lu} <= '0;
                    bus.mem_a      <= '0;
                    bus.mem_wd     <= '0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= r_we ? '0 : extend(r_f3, bus.mem_rd);
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                SPLIT: begin
                    asm <= asm_next;
                    if (k == ((r_f3[1:0] == 2'b01) ? 2'd1 : 2'd3)) begin
                        state          <= RESP;
                        {bus.mem_we, bus.mem_lb, bus.mem_lh, bus.mem_sb, bus.mem_sh, bus.mem_lu} <= '0;
                        bus.mem_a      <= '0;
                        bus.mem_wd     <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= r_we ? '0 : extend(r_f3, asm_next);
                    end else begin
                        k          <= k + 2'd1;
                        bus.mem_a  <= bus.mem_a + `XLEN'(1);
                        bus.mem_wd <= r_we ? `XLEN'(wsh[7:0]) : '0;
                        wsh        <= wsh >> 8;
                    end
                end
`endif
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port: vector table of single requests plus
// back-to-back and reset-abort sequences, against a byte-array memory.
`ifndef XLEN
`define XLEN 32
`endif

module tb_lsu_dmem_port;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_dmem_port_if bus();
    lsu_dmem_port dut (.clk(clk), .reset(reset), .bus(bus));

    // Byte memory, little-endian, 1 KiB wrapping; read is combinational
    logic [7:0] mem [0:1023];
    logic [9:0] ma;
    assign ma = bus.mem_a[9:0];
    assign bus.mem_rd = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if ((i == 0) ||
                    (i == 1 && bus.mem_sb) ||
                    (i >= 2 && bus.mem_sb && bus.mem_sh))
                    mem[ma + 10'(i)] <= bus.mem_wd[8*i +: 8];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic mem_busy();
        return bus.mem_we | bus.mem_lb | bus.mem_lh | bus.mem_sb | bus.mem_sh |
               bus.mem_lu | (|bus.mem_a) | (|bus.mem_wd);
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input logic mis,
                          input logic exp_err, input int exp_lat, input int exp_memc,
                          input string name);
        int lat, memc, wec, rdy;
        logic got, er;
        logic [31:0] rd;
        logic [1:0] exp_sz;
        exp_sz = mis ? 2'b01 : (f3[1:0] == 2'b00) ? 2'b01 : (f3[1:0] == 2'b01) ? 2'b10 : 2'b11;
        @(negedge clk);
        check({name, " idle ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        got = 1'b0; lat = 0; memc = 0; wec = 0; rdy = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready) rdy++;
            if (bus.resp_valid) begin
                got = 1'b1; lat = c; rd = bus.resp_rdata; er = bus.resp_err;
                check({name, " mem quiet in resp"}, 32'(mem_busy()), 32'd0);
            end else if (mem_busy()) begin
                check({name, " mem_a"}, bus.mem_a, addr + (mis ? 32'(memc) : 32'd0));
                check({name, " size"}, 32'(we ? {bus.mem_sb, bus.mem_sh} : {bus.mem_lb, bus.mem_lh}),
                      32'(exp_sz));
                check({name, " lu"}, 32'(bus.mem_lu), 32'(mis ? 1'b1 : f3[2]));
                if (we && !mis) check({name, " mem_wd"}, bus.mem_wd, wdata);
                memc++;
                if (bus.mem_we) wec++;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " rdata"}, rd, exp_rd);
        check({name, " err"}, 32'(er), 32'(exp_err));
        check({name, " mem cycles"}, 32'(memc), 32'(exp_memc));
        check({name, " write cycles"}, 32'(wec), (we && !exp_err) ? 32'(exp_memc) : 32'd0);
        check({name, " ready while busy"}, 32'(rdy), 32'd0);
        @(negedge clk);
        check({name, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
        check({name, " ready after"}, 32'(bus.req_ready), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          lat;
        int          memc;
    } vec_t;

    vec_t v[17];
    logic [31:0] b2b_addr [3];
    logic [2:0]  b2b_f3   [3];
    logic [31:0] b2b_exp  [3];

    initial begin
        int nacc, nresp, stalled, nrv;
        int acc_cyc [3];
        logic accept;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h0FE] = 8'hAA;
        mem[10'h0FF] = 8'hBB;

        //          we    f3      addr          wdata          rdata         mis   err  lat memc
        v[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 2, 1};
        v[1]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1};
        v[2]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_0080, 32'h0000_0000, 1'b0, 1'b0, 2, 1};
        v[3]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 2, 1};
        v[4]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 2, 1};
        v[5]  = '{1'b1, 3'b001, 32'h0000_0300, 32'h1234_ABCD, 32'h0000_0000, 1'b0, 1'b0, 2, 1};
        v[6]  = '{1'b0, 3'b001, 32'h0000_0300, 32'h0,         32'hFFFF_ABCD, 1'b0, 1'b0, 2, 1};
        v[7]  = '{1'b0, 3'b101, 32'h0000_0300, 32'h0,         32'h0000_ABCD, 1'b0, 1'b0, 2, 1};
        v[8]  = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h0000_ABCD, 1'b0, 1'b0, 2, 1};
        v[9]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'h00DE_ADBE, 1'b1, 1'b0, 5, 4};
        v[10] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,         32'h0000_00DE, 1'b1, 1'b0, 3, 2};
        v[11] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 1, 0};
        v[12] = '{1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1, 0};
        v[13] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 1, 0};
        v[14] = '{1'b1, 3'b011, 32'h0000_0100, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 1, 0};
        v[15] = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 1'b0, 1'b0, 2, 1};
        v[16] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1};

        b2b_addr[0] = 32'h100; b2b_f3[0] = 3'b010; b2b_exp[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 32'h300; b2b_f3[1] = 3'b010; b2b_exp[1] = 32'h0000_ABCD;
        b2b_addr[2] = 32'h203; b2b_f3[2] = 3'b100; b2b_exp[2] = 32'h0000_0080;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset ready", 32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_err", 32'(bus.resp_err), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        check("reset mem outputs", 32'(mem_busy()), 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (v[i].mis && !SPLIT_EN) begin
                v[i].err = 1'b1; v[i].rdata = '0; v[i].lat = 1; v[i].memc = 0;
            end
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, v[i].rdata, v[i].mis,
                   v[i].err, v[i].lat, v[i].memc, $sformatf("vec%0d", i));
        end

        // Back-to-back aligned loads with req_valid held high
        @(negedge clk);
        nacc = 0; nresp = 0; stalled = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0;
        bus.req_funct3 = b2b_f3[0]; bus.req_addr = b2b_addr[0];
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            if (bus.resp_valid) begin
                check($sformatf("b2b resp%0d", nresp), bus.resp_rdata, b2b_exp[nresp]);
                nresp++;
            end
            accept = bus.req_valid && bus.req_ready;
            if (accept) begin
                acc_cyc[nacc] = c;
                nacc++;
            end else if (bus.req_valid) begin
                stalled++;
            end
            @(posedge clk);
            #1;
            if (accept) begin
                if (nacc < 3) begin
                    bus.req_funct3 = b2b_f3[nacc];
                    bus.req_addr   = b2b_addr[nacc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b accepted", 32'(nacc), 32'd3);
        check("b2b responses", 32'(nresp), 32'd3);
        check("b2b stalled cycles", 32'(stalled), 32'd4);
        check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

        // Split SW to 0x0FE, reset during its k=1 cycle (rejected without split)
        if (SPLIT_EN) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
            bus.req_addr = 32'h0FE; bus.req_wdata = 32'h1122_3344;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            @(negedge clk);
            check("split k0 addr", bus.mem_a, 32'h0FE);
            check("split k0 we", 32'(bus.mem_we), 32'd1);
            check("split k0 wd", bus.mem_wd, 32'h44);
            @(negedge clk);
            check("split k1 addr", bus.mem_a, 32'h0FF);
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("abort ready", 32'(bus.req_ready), 32'd1);
            check("abort mem quiet", 32'(mem_busy()), 32'd0);
            check("abort byte0 written", 32'(mem[10'h0FE]), 32'h44);
            check("abort byte2 untouched", 32'(mem[10'h100]), 32'hEF);
        end else begin
            do_req(1'b1, 3'b010, 32'h0FE, 32'h1122_3344, 32'h0, 1'b1, 1'b1, 1, 0, "mis sw");
            check("mis sw byte0 untouched", 32'(mem[10'h0FE]), 32'hAA);
            check("mis sw byte1 untouched", 32'(mem[10'h0FF]), 32'hBB);
        end
        nrv = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) nrv++;
            @(negedge clk);
        end
        check("abort no response", 32'(nrv), 32'd0);

        // Reset during ACCESS of an aligned load
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h100; bus.req_wdata = '0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("access abort addr", bus.mem_a, 32'h100);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        nrv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) nrv++;
        end
        check("access abort no response", 32'(nrv), 32'd0);
        check("access abort ready", 32'(bus.req_ready), 32'd1);

        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu_dmem_port.md
LSU_DMEM_PORT -- requirements
Module: lsu_dmem_port

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, with reset synchronous and active-high.
REQ-003 SHALL have ports req_valid (input, 1) and req_ready (output, 1): core request handshake; a transfer occurs at a rising edge where both are 1.
REQ-004 SHALL have inputs req_we (1; 1=store), req_funct3 (3; RISC-V load/store funct3), req_addr (`XLEN) and req_wdata (`XLEN).
REQ-005 SHALL have outputs resp_valid (1; one-cycle pulse), resp_rdata (`XLEN; load result) and resp_err (1; request rejected).
REQ-006 SHALL have outputs mem_we (1), mem_a (`XLEN) and mem_wd (`XLEN), which drive the data memory.
REQ-007 SHALL have outputs mem_lb, mem_lh, mem_sb and mem_sh (1 each). {lb,lh} and {sb,sh} are size codes: 11=word, 10=half, 01=byte.
REQ-008 SHALL have output mem_lu (1; unsigned load) and input mem_rd (`XLEN). mem_rd is combinational and valid in the same cycle as mem_a; the memory writes at the rising edge when mem_we=1.

Function
REQ-009 SHALL implement states IDLE, ACCESS, SPLIT and RESP.
REQ-010 In IDLE, SHALL drive req_ready=1. In all other states, SHALL drive req_ready=0, and req_valid is ignored.
REQ-011 On transfer, SHALL register we, funct3, addr and wdata. The next state SHALL be one of:
- RESP with error flag set, if the request is invalid or rejected as misaligned;
- SPLIT, if misaligned and splitting is enabled;
- ACCESS, otherwise.
REQ-012 Valid funct3 SHALL be: loads 000/001/010/100/101 (LB/LH/LW/LBU/LHU); stores 000/001/010. Any other funct3 SHALL be invalid.
REQ-013 Alignment rules SHALL be: half is misaligned when addr[0]=1; word is misaligned when addr[1:0]!=00.
REQ-014 ACCESS SHALL last exactly one cycle:
- drive mem_a=addr and the size code from funct3;
- drive mem_lu=funct3[2];
- for stores, drive mem_we=1 and mem_wd=wdata;
- for loads, capture mem_rd at the cycle end.
Next state SHALL be RESP.
REQ-015 SPLIT SHALL use a byte counter k = 0..N-1 (N=2 half, N=4 word), one byte access per cycle:
- mem_a = addr+k (mod 2^32), byte size code, mem_lu=1;
- stores: mem_wd[7:0] = wdata byte k;
- loads: mem_rd[7:0] placed into assembly bits [8k+7:8k].
After k=N-1, next state SHALL be RESP.
REQ-016 In RESP, SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE.
REQ-017 resp_rdata SHALL be: load data (sign-extended for LB/LH, zero-extended for LBU/LHU, as-is for LW); 0 for stores or when resp_err=1.
REQ-018 resp_err SHALL be 1 only in RESP for invalid or rejected requests. Such requests SHALL cause no memory access.
REQ-019 Outside ACCESS and SPLIT, all mem_* outputs SHALL be 0.
REQ-020 Latency from the transfer edge to resp_valid SHALL be: aligned 2 cycles; split N+1 cycles; error 1 cycle.
REQ-021 Back-to-back operation: a new transfer SHALL be possible in the cycle after RESP. Throughput for aligned requests SHALL be 1 request per 3 cycles.

Reset
REQ-022 When reset=1 at a rising edge, SHALL set state IDLE, k=0, and all registered request fields to 0.
REQ-023 After reset, outputs SHALL be: req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; all mem_* outputs 0.
REQ-024 Reset during SPLIT or ACCESS SHALL abort the operation with no response. Bytes already written SHALL remain in memory.

Configuration
REQ-025 Macro LSU_MISALIGN_SPLIT_EN:
- defined: misaligned half/word requests SHALL be executed via SPLIT;
- undefined: SPLIT SHALL be absent, and misaligned requests SHALL complete with resp_err=1 and no memory access.

Verification
REQ-026 Aligned SW 0xDEADBEEF to 0x100, then LW 0x100 -> one ACCESS cycle with mem_we=1, {sb,sh}=11; LW returns 0xDEADBEEF with resp_err=0 and 2-cycle latency.
REQ-027 SB 0x80 to 0x203, then LB 0x203 and LBU 0x203 -> resp_rdata 0xFFFFFF80 and 0x00000080 respectively.
REQ-028 LW from 0x101 with macro defined -> four byte reads at 0x101..0x104, correct assembly, resp_valid after 5 cycles. Without macro -> resp_err=1, mem_we never 1, resp_rdata=0.
REQ-029 funct3=011 load, and store with funct3=100 -> resp_err=1 after 1 cycle, no mem_* activity.
REQ-030 Assert reset during the k=1 cycle of a split SW 0x11223344 to 0x0FE -> byte 0x44 written, no resp_valid, req_ready=1 the cycle after reset.
REQ-031 req_valid held high for 3 back-to-back aligned LWs -> req_ready=0 while busy, each request accepted exactly once, responses in order.
